// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared memory-access constants, state encoding and access-size decode
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } access_size_t;

    // Stores only define B/H/W; loads add BU/HU. Anything else is a word access.
    function automatic access_size_t access_size(input logic [2:0] func3, input logic is_store);
        access_size_t size;
        size = SZ_WORD;
        if (func3 == F3_B || (!is_store && func3 == F3_BU)) begin
            size = SZ_BYTE;
        end else if (func3 == F3_H || (!is_store && func3 == F3_HU)) begin
            size = SZ_HALF;
        end
        return size;
    endfunction

    // Bytes are never misaligned; halfwords need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_misaligned(input access_size_t size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/strobes and load lane extraction/extension
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_st_func3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_wstrb,
    input  logic [2:0]  i_ld_func3,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    access_size_t w_st_size;
    access_size_t w_ld_size;
    logic         w_ld_signed;
    logic [7:0]   w_ld_byte;
    logic [15:0]  w_ld_half;

    assign w_st_size   = access_size(i_st_func3, 1'b1);
    assign w_ld_size   = access_size(i_ld_func3, 1'b0);
    // LB/LH have func3[2]=0; the unsigned variants set it.
    assign w_ld_signed = ~i_ld_func3[2];

    // Replicate store data across lanes so the slave only needs the strobes.
    always_comb begin
        o_st_wdata = i_st_data;
        o_st_wstrb = 4'b1111;
        case (w_st_size)
            SZ_BYTE: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_addr_lo;
            end
            SZ_HALF: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte/halfword lane out of the returned word.
    always_comb begin
        w_ld_byte = i_ld_rdata[7:0];
        case (i_ld_lane)
            2'd1:    w_ld_byte = i_ld_rdata[15:8];
            2'd2:    w_ld_byte = i_ld_rdata[23:16];
            2'd3:    w_ld_byte = i_ld_rdata[31:24];
            default: w_ld_byte = i_ld_rdata[7:0];
        endcase
        w_ld_half = i_ld_lane[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    end

    // Sign- or zero-extend the selected lane to 32 bits.
    always_comb begin
        o_ld_data = i_ld_rdata;
        case (w_ld_size)
            SZ_BYTE: o_ld_data = {{24{w_ld_signed & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_ld_data = {{16{w_ld_signed & w_ld_half[15]}}, w_ld_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage driving a valid/ready data bus ahead of stage2
module mem_access_stage #(
    parameter int         TIMEOUT         = 16,
    parameter logic [1:0] RESULT_SRC_LOAD = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_wed,
    input  logic [1:0]  in_result_src,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_write_data,
    input  logic [2:0]  in_func3,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [31:0] o_read_data,
    output logic        o_mem_stall,
    output logic        o_misaligned,
    output logic        o_bus_fault
);

    import riscv_pkg::*;

    mem_state_t  r_state;
    mem_state_t  w_next_state;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_wstrb;
    logic [31:0] r_read_data;
    logic        r_bus_fault;
    logic [2:0]  r_func3;
    logic [1:0]  r_lane;
    logic [31:0] r_wait_cnt;

    logic        w_is_load;
    logic        w_access;
    logic        w_misaligned;
    logic        w_start;
    logic        w_timeout;
    logic        w_mem_stall;
    logic        w_misaligned_flag;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_ld_data;

    assign w_is_load    = (in_result_src == RESULT_SRC_LOAD);
    assign w_access     = (in_wed | w_is_load) & ~flush;
    assign w_misaligned = is_misaligned(access_size(in_func3, in_wed), in_alu_result[1:0]);
    assign w_start      = (r_state == ST_IDLE) & w_access & ~w_misaligned;
    // The counter holds the number of completed wait cycles, so the last allowed one is TIMEOUT-1.
    assign w_timeout    = (TIMEOUT > 0) && !bus_ready && (r_wait_cnt == 32'(TIMEOUT - 1));

    lsu_align u_align (
        .i_st_func3   (in_func3),
        .i_st_addr_lo (in_alu_result[1:0]),
        .i_st_data    (in_write_data),
        .o_st_wdata   (w_st_wdata),
        .o_st_wstrb   (w_st_wstrb),
        .i_ld_func3   (r_func3),
        .i_ld_lane    (r_lane),
        .i_ld_rdata   (bus_rdata),
        .o_ld_data    (w_ld_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a started access always runs to DONE; flush only matters in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next_state = ST_ACCESS;
            ST_ACCESS: if (bus_ready || w_timeout) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Combinational stall and misalignment flags; DONE releases the pipeline for one cycle.
    always_comb begin
        w_mem_stall       = 1'b0;
        w_misaligned_flag = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_mem_stall       = w_start;
                w_misaligned_flag = w_access & w_misaligned;
            end
            ST_ACCESS: w_mem_stall = 1'b1;
            default: begin
                w_mem_stall       = 1'b0;
                w_misaligned_flag = 1'b0;
            end
        endcase
    end

    // Bus request latching, wait counting, load result capture and fault pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_bus_wstrb <= 4'h0;
            r_read_data <= 32'h0;
            r_bus_fault <= 1'b0;
            r_func3     <= 3'b000;
            r_lane      <= 2'b00;
            r_wait_cnt  <= 32'h0;
        end else begin
            r_bus_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= in_wed;
                        r_bus_addr  <= {in_alu_result[31:2], 2'b00};
                        r_bus_wdata <= in_wed ? w_st_wdata : 32'h0;
                        r_bus_wstrb <= in_wed ? w_st_wstrb : 4'h0;
                        r_func3     <= in_func3;
                        r_lane      <= in_alu_result[1:0];
                        r_wait_cnt  <= 32'h0;
                    end
                end
                ST_ACCESS: begin
                    if (bus_ready) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_read_data <= w_ld_data;
                        end
                    end else if (w_timeout) begin
                        r_bus_req   <= 1'b0;
                        r_bus_fault <= 1'b1;
                        r_read_data <= 32'h0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_wstrb    = r_bus_wstrb;
    assign o_read_data  = r_read_data;
    assign o_mem_stall  = w_mem_stall;
    assign o_misaligned = w_misaligned_flag;
    assign o_bus_fault  = r_bus_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    import riscv_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_wed;
    logic [1:0]  in_result_src;
    logic [31:0] in_alu_result;
    logic [31:0] in_write_data;
    logic [2:0]  in_func3;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [31:0] o_read_data;
    logic        o_mem_stall;
    logic        o_misaligned;
    logic        o_bus_fault;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TMO), .RESULT_SRC_LOAD(2'b01)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_wed        (in_wed),
        .in_result_src (in_result_src),
        .in_alu_result (in_alu_result),
        .in_write_data (in_write_data),
        .in_func3      (in_func3),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .o_read_data   (o_read_data),
        .o_mem_stall   (o_mem_stall),
        .o_misaligned  (o_misaligned),
        .o_bus_fault   (o_bus_fault)
    );

    int n_vec = 0;
    int n_err = 0;
    int s_cnt = 0;

    logic        e_valid = 1'b0;
    logic        e_req, e_stall, e_mis, e_fault, e_bus, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] m_rd = 32'h0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3, input logic st);
        int n;
        case (f3)
            3'b000:  n = 1;
            3'b001:  n = 2;
            3'b100:  n = st ? 4 : 1;
            3'b101:  n = st ? 4 : 2;
            default: n = 4;
        endcase
        return n;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic st, input logic [31:0] a);
        return (a % 32'(m_size(f3, st))) != 32'd0;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic st, input logic [31:0] a);
        int n;
        if (!st) return 4'h0;
        n = m_size(f3, st);
        return 4'(((32'd1 << n) - 32'd1) << (a % 32'd4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic st, input logic [31:0] d);
        int n;
        if (!st) return 32'h0;
        n = m_size(f3, st);
        if (n == 1) return {4{d[7:0]}};
        if (n == 2) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int n;
        n = m_size(f3, 1'b0);
        v = rd >> (32'd8 * (a % 32'd4));
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Compare process: every negedge with expectations armed.
    always @(negedge clk) begin
        if (e_valid) begin
            cmp("bus_req",   32'(bus_req),      32'(e_req));
            cmp("stall",     32'(o_mem_stall),  32'(e_stall));
            cmp("misaligned",32'(o_misaligned), 32'(e_mis));
            cmp("bus_fault", 32'(o_bus_fault),  32'(e_fault));
            cmp("read_data", o_read_data,       m_rd);
            if (e_bus) begin
                cmp("bus_we",    32'(bus_we),    32'(e_we));
                cmp("bus_addr",  bus_addr,       e_addr);
                cmp("bus_wdata", bus_wdata,      e_wdata);
                cmp("bus_wstrb", 32'(bus_wstrb), 32'(e_wstrb));
            end
        end
    end

    task automatic expect_now(input logic req, input logic stall, input logic mis, input logic fault,
                              input logic bus, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] st);
        e_req = req; e_stall = stall; e_mis = mis; e_fault = fault;
        e_bus = bus; e_we = we; e_addr = a; e_wdata = wd; e_wstrb = st;
        e_valid = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        s_cnt += int'(o_mem_stall);
        @(posedge clk);
        #1;
    endtask

    // waits < 0 means the slave never answers (timeout).
    task automatic run_op(input string tag, input logic we, input logic ld, input logic fl,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd,
                          output logic [31:0] c_addr, output logic [31:0] c_wdata,
                          output logic [3:0] c_wstrb);
        logic acc, mis, go;
        int   nacc;
        acc  = (we | ld) & ~fl;
        mis  = m_mis(f3, we, addr);
        go   = acc & ~mis;
        nacc = (waits < 0) ? TMO : waits + 1;
        c_addr = 32'h0; c_wdata = 32'h0; c_wstrb = 4'h0;
        s_cnt = 0;
        in_wed = we; in_result_src = ld ? 2'b01 : 2'b00; flush = fl;
        in_func3 = f3; in_alu_result = addr; in_write_data = wd;
        expect_now(1'b0, go, acc & mis, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        in_wed = 1'b0; in_result_src = 2'b00; flush = 1'b0;
        if (go) begin
            for (int k = 0; k < nacc; k++) begin
                bus_ready = (waits >= 0) && (k == waits);
                bus_rdata = bus_ready ? rd : (32'hCAFE_F00D ^ 32'(k));
                expect_now(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, we, addr - (addr % 32'd4),
                           m_wdata(f3, we, wd), m_wstrb(f3, we, addr));
                @(negedge clk);
                s_cnt += int'(o_mem_stall);
                c_addr = bus_addr; c_wdata = bus_wdata; c_wstrb = bus_wstrb;
                @(posedge clk);
                #1;
            end
            bus_ready = 1'b0; bus_rdata = 32'h0;
            if (waits < 0) m_rd = 32'h0;
            else if (!we) m_rd = m_load(f3, addr, rd);
            expect_now(1'b0, 1'b0, 1'b0, waits < 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            tick();
        end
        expect_now(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        cmp({tag, "_stall_cycles"}, 32'(s_cnt), go ? 32'(nacc + 1) : 32'd0);
    endtask

    logic [31:0] ca, cw;
    logic [3:0]  cs;

    initial begin
        rst = 1'b1; flush = 1'b0; in_wed = 1'b0; in_result_src = 2'b00;
        in_alu_result = 32'h0; in_write_data = 32'h0; in_func3 = 3'b000;
        bus_ready = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        expect_now(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        run_op("lw", 1'b0, 1'b1, 1'b0, F3_W, 32'h100, 32'h0, 0, 32'hDEADBEEF, ca, cw, cs);
        cmp("lw_rdata_lit", o_read_data, 32'hDEADBEEF);
        cmp("lw_addr_lit", ca, 32'h100);
        cmp("lw_wstrb_lit", 32'(cs), 32'h0);

        run_op("lb", 1'b0, 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 1, 32'h80FF_FF7F, ca, cw, cs);
        cmp("lb_rdata_lit", o_read_data, 32'hFFFF_FF80);
        run_op("lbu", 1'b0, 1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 0, 32'h80FF_FF7F, ca, cw, cs);
        cmp("lbu_rdata_lit", o_read_data, 32'h0000_0080);
        run_op("lhu", 1'b0, 1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 2, 32'h80FF_FF7F, ca, cw, cs);
        cmp("lhu_rdata_lit", o_read_data, 32'h0000_80FF);

        run_op("sb", 1'b1, 1'b0, 1'b0, F3_B, 32'h201, 32'h0000_00A5, 3, 32'h0, ca, cw, cs);
        cmp("sb_wdata_lit", cw, 32'hA5A5_A5A5);
        cmp("sb_wstrb_lit", 32'(cs), 32'h2);
        cmp("sb_addr_lit", ca, 32'h200);
        cmp("sb_rdata_kept_lit", o_read_data, 32'h0000_80FF);

        run_op("sh", 1'b1, 1'b0, 1'b0, F3_H, 32'h302, 32'h0000_BBBB, 1, 32'h0, ca, cw, cs);
        cmp("sh_wstrb_lit", 32'(cs), 32'hC);
        cmp("sh_wdata_lit", cw, 32'hBBBB_BBBB);

        run_op("lw_mis", 1'b0, 1'b1, 1'b0, F3_W, 32'h305, 32'h0, 0, 32'h1111_1111, ca, cw, cs);
        run_op("sh_mis", 1'b1, 1'b0, 1'b0, F3_H, 32'h301, 32'h1234, 0, 32'h0, ca, cw, cs);
        cmp("mis_rdata_kept_lit", o_read_data, 32'h0000_80FF);

        run_op("lh", 1'b0, 1'b1, 1'b0, F3_H, 32'h102, 32'h0, 0, 32'h80FF_1234, ca, cw, cs);
        cmp("lh_rdata_lit", o_read_data, 32'hFFFF_80FF);

        run_op("sw", 1'b1, 1'b0, 1'b0, F3_W, 32'h40C, 32'h1234_5678, 2, 32'h0, ca, cw, cs);
        cmp("sw_wstrb_lit", 32'(cs), 32'hF);
        cmp("sw_wdata_lit", cw, 32'h1234_5678);

        run_op("lw_timeout", 1'b0, 1'b1, 1'b0, F3_W, 32'h500, 32'h0, -1, 32'h0, ca, cw, cs);
        cmp("timeout_rdata_lit", o_read_data, 32'h0);

        run_op("flush", 1'b0, 1'b1, 1'b1, F3_W, 32'h600, 32'h0, 0, 32'h7777_7777, ca, cw, cs);

        run_op("lb_pos", 1'b0, 1'b1, 1'b0, F3_B, 32'h110, 32'h0, 0, 32'hFFFF_FF7F, ca, cw, cs);
        cmp("lb_pos_rdata_lit", o_read_data, 32'h0000_007F);

        // Reset while the bus is still waiting.
        in_result_src = 2'b01; in_func3 = F3_W; in_alu_result = 32'h700; in_wed = 1'b0;
        expect_now(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        in_result_src = 2'b00;
        for (int k = 0; k < 2; k++) begin
            expect_now(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
            tick();
        end
        rst = 1'b1;
        expect_now(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        tick();
        rst = 1'b0;
        m_rd = 32'h0;
        expect_now(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        cmp("rst_rdata_lit", o_read_data, 32'h0);
        cmp("rst_bus_req_lit", 32'(bus_req), 32'h0);

        run_op("lw_after_rst", 1'b0, 1'b1, 1'b0, F3_W, 32'h104, 32'h0, 0, 32'h0000_5A5A, ca, cw, cs);
        cmp("lw_after_rst_lit", o_read_data, 32'h0000_5A5A);

        e_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
